// File: rtl/sw_debounce7.sv
`default_nettype none
// ============================================================================
// Module  : sw_debounce7
// Brief   : 2-flop synchroniser + per-bit stability-counter debounce for seven
//           switch inputs, with change strobe/mask. Optional sticky change
//           flags when `DB_STICKY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module sw_debounce7 #(
    parameter int         STABLE_CYCLES = 16,
    parameter int         CNT_W         = 5,
    parameter logic [6:0] RST_VAL       = 7'b0000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] sw_raw,
`ifdef DB_STICKY_EN
    input  logic       sticky_clr,
    output logic [6:0] sticky,
`endif
    output logic [6:0] db_out,
    output logic       chg_pulse,
    output logic [6:0] chg_mask,
    output logic       stable
);

    localparam int             c_NBITS   = 7;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [c_NBITS-1:0]            s1_q, s1_d;
    logic [c_NBITS-1:0]            s2_q, s2_d;
    logic [c_NBITS-1:0]            db_q, db_d;
    logic [c_NBITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [c_NBITS-1:0]            mask_q, mask_d;
    logic                          pulse_q, pulse_d;
    logic                          stable_q, stable_d;
    logic [c_NBITS-1:0]            w_busy;

    always_comb begin
        s1_d   = sw_raw;
        s2_d   = s1_q;
        db_d   = db_q;
        mask_d = '0;
        cnt_d  = '0;
        w_busy = '0;
        for (int i = 0; i < c_NBITS; i++) begin
            // Any return to the accepted level throws away the partial count.
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_CNT_MAX) begin
                db_d[i]   = s2_q[i];
                mask_d[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + c_CNT_ONE;
            end
            w_busy[i] = |cnt_d[i];
        end
        pulse_d  = |mask_d;
        stable_d = (s2_d == db_d) && (w_busy == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= RST_VAL;
            s2_q     <= RST_VAL;
            db_q     <= RST_VAL;
            cnt_q    <= '0;
            mask_q   <= '0;
            pulse_q  <= 1'b0;
            stable_q <= 1'b1;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            pulse_q  <= pulse_d;
            stable_q <= stable_d;
        end
    end

    assign db_out    = db_q;
    assign chg_pulse = pulse_q;
    assign chg_mask  = mask_q;
    assign stable    = stable_q;

`ifdef DB_STICKY_EN
    logic [c_NBITS-1:0] sticky_q, sticky_d;

    // New events are OR-ed in after the clear so a coincident event survives.
    always_comb begin
        sticky_d = (sticky_q & ~{c_NBITS{sticky_clr}}) | mask_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce7.sv
`default_nettype none
// ============================================================================
// Module  : tb_sw_debounce7
// Brief   : Directed vector bench for sw_debounce7 (STABLE_CYCLES=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sw_debounce7;

    logic       clk;
    logic       rst_n;
    logic [6:0] sw_raw;
    logic [6:0] db_out;
    logic       chg_pulse;
    logic [6:0] chg_mask;
    logic       stable;
`ifdef DB_STICKY_EN
    logic       sticky_clr;
    logic [6:0] sticky;
`endif

    int checks = 0;
    int errors = 0;

    sw_debounce7 #(
        .STABLE_CYCLES(4),
        .CNT_W        (5),
        .RST_VAL      (7'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
`ifdef DB_STICKY_EN
        .sticky_clr(sticky_clr),
        .sticky    (sticky),
`endif
        .db_out    (db_out),
        .chg_pulse (chg_pulse),
        .chg_mask  (chg_mask),
        .stable    (stable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic [6:0] sw;
        logic [6:0] db;
        logic       pulse;
        logic [6:0] mask;
        logic       stable;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sw_raw = 7'h00;
`ifdef DB_STICKY_EN
        sticky_clr = 1'b0;
`endif
        // Reset with all inputs high, then release: rise lands 6 edges later, then fall.
        vecs[0]  = '{1'b0, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b1};
        vecs[1]  = '{1'b0, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b1};
        vecs[2]  = '{1'b1, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b1};
        vecs[3]  = '{1'b1, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b0};
        vecs[4]  = '{1'b1, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b0};
        vecs[5]  = '{1'b1, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b0};
        vecs[6]  = '{1'b1, 7'h7F, 7'h00, 1'b0, 7'h00, 1'b0};
        vecs[7]  = '{1'b1, 7'h7F, 7'h7F, 1'b1, 7'h7F, 1'b1};
        vecs[8]  = '{1'b1, 7'h7F, 7'h7F, 1'b0, 7'h00, 1'b1};
        vecs[9]  = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b1};
        vecs[10] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b0};
        vecs[11] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b0};
        vecs[12] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b0};
        vecs[13] = '{1'b1, 7'h00, 7'h7F, 1'b0, 7'h00, 1'b0};
        vecs[14] = '{1'b1, 7'h00, 7'h00, 1'b1, 7'h7F, 1'b1};
        vecs[15] = '{1'b1, 7'h00, 7'h00, 1'b0, 7'h00, 1'b1};

        for (int i = 0; i < 16; i++) begin
            rst_n  = vecs[i].rst_n;
            sw_raw = vecs[i].sw;
            step();
            check($sformatf("vec%0d_db", i),     db_out,    vecs[i].db);
            check($sformatf("vec%0d_pulse", i),  chg_pulse, vecs[i].pulse);
            check($sformatf("vec%0d_mask", i),   chg_mask,  vecs[i].mask);
            check($sformatf("vec%0d_stable", i), stable,    vecs[i].stable);
        end

        // Glitch: bit2 high for 3 cycles only.
        sw_raw = 7'h04;
        for (int j = 0; j < 12; j++) begin
            if (j == 3) sw_raw = 7'h00;
            step();
            check("glitch_db", db_out, 7'h00);
            check("glitch_pulse", chg_pulse, 1'b0);
        end
        check("glitch_stable", stable, 1'b1);

        // Single bit6 rise, update at 6th edge (j==5).
        sw_raw = 7'h40;
        for (int j = 0; j < 10; j++) begin
            step();
            check("bit6_db",    db_out,   (j >= 5) ? 7'h40 : 7'h00);
            check("bit6_mask",  chg_mask, (j == 5) ? 7'h40 : 7'h00);
            check("bit6_pulse", chg_pulse, (j == 5));
        end
        sw_raw = 7'h00;
        for (int j = 0; j < 10; j++) step();
        check("bit6_fall_db", db_out, 7'h00);

        // Bits 0,3 together; bit1 one cycle later.
        sw_raw = 7'h09;
        for (int j = 0; j < 10; j++) begin
            if (j == 1) sw_raw = 7'h0B;
            step();
            check("simul_db",    db_out,   (j >= 6) ? 7'h0B : (j == 5) ? 7'h09 : 7'h00);
            check("simul_mask",  chg_mask, (j == 5) ? 7'h09 : (j == 6) ? 7'h02 : 7'h00);
            check("simul_pulse", chg_pulse, (j == 5) || (j == 6));
        end
        sw_raw = 7'h00;
        for (int j = 0; j < 12; j++) step();
        check("simul_fall_db", db_out, 7'h00);

        // Reset while bit4 counter is at 2.
        sw_raw = 7'h10;
        for (int j = 0; j < 4; j++) step();
        check("rstmid_pre_db", db_out, 7'h00);
        rst_n = 1'b0;
        step();
        check("rstmid_db",     db_out,    7'h00);
        check("rstmid_pulse",  chg_pulse, 1'b0);
        check("rstmid_mask",   chg_mask,  7'h00);
        check("rstmid_stable", stable,    1'b1);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            check("rstmid_db_after",    db_out,   (j >= 5) ? 7'h10 : 7'h00);
            check("rstmid_pulse_after", chg_pulse, (j == 5));
        end

`ifdef DB_STICKY_EN
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_init_clr", sticky, 7'h00);
        sw_raw = 7'h30;
        for (int j = 0; j < 10; j++) begin
            step();
            check("sticky_set", sticky, (j >= 5) ? 7'h20 : 7'h00);
            check("sticky_set_db", db_out, (j >= 5) ? 7'h30 : 7'h10);
        end
        // Clear coincides with the second bit5 event: the event must survive.
        sw_raw = 7'h10;
        for (int j = 0; j < 10; j++) begin
            sticky_clr = (j == 5);
            step();
            check("sticky_race", sticky, 7'h20);
            check("sticky_race_mask", chg_mask, (j == 5) ? 7'h20 : 7'h00);
        end
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_clear", sticky, 7'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
